// File: rtl/uart_frame_pkg.sv
// ---- uart_frame_pkg : shared types and helpers for the UART frame controller, rev 1.0 ----
`default_nettype none

package uart_frame_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CHK     = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CHK  = 2'd2;
  localparam logic [1:0] ERR_TO   = 2'd3;

  // One byte time is 10 bit periods; 64-bit math keeps large clock rates from overflowing.
  function automatic int unsigned timeout_cycles(input int unsigned clk_freq,
                                                 input int unsigned bps,
                                                 input int unsigned to_bytes);
    logic [63:0] c;
    c = (64'(to_bytes) * 64'd10 * 64'(clk_freq)) / 64'(bps);
    return 32'(c);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_frame_buf.sv
// ---- uart_frame_buf : payload register file, one write port, one registered read port, rev 1.0 ----
`default_nettype none

module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)  rd_data <= 8'd0;
    else if (rd_en)  rd_data <= mem[rd_addr];
  end

endmodule

`default_nettype wire

// File: rtl/uart_frame_ctrl.sv
// ---- uart_frame_ctrl : UART receive framing (header, length, payload, checksum, timeout), rev 1.0 ----
`default_nettype none

module uart_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int          CLK_FREQ = 50000000,
  parameter int          UART_BPS = 9600,
  parameter logic [7:0]  HDR_BYTE = 8'h55,
  parameter int          MAX_LEN  = 16,
  parameter int          TO_BYTES = 3
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       pl_valid,
  output logic [7:0] pl_data,
  output logic       pl_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int unsigned TO_CYC    = timeout_cycles(CLK_FREQ, UART_BPS, TO_BYTES);
  localparam int          TO_W      = $clog2(TO_CYC + 1);
  localparam int          AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

  state_t          state;
  logic [7:0]      acc;
  logic [7:0]      frame_len;
  logic [7:0]      idx;
  logic [7:0]      rd;
  logic [TO_W-1:0] to_cnt;
  logic            pend_valid;
  logic [7:0]      pend_data;

  logic            active;
  logic            in_v;
  logic [7:0]      in_d;
  logic [7:0]      sum;
  logic            to_hit;
  logic            chk_ok;
  logic            wr_en;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;

  // A byte parked during DRAIN is consumed ahead of the live input once DRAIN exits.
  always_comb begin
    active  = (state == LEN) || (state == PAYLOAD) || (state == CHK);
    in_v    = (state != DRAIN) && (pend_valid || rx_done);
    in_d    = pend_valid ? pend_data : rx_data;
    sum     = acc + in_d;
    to_hit  = active && !in_v && (to_cnt == TO_W'(TO_CYC - 1));
    chk_ok  = (state == CHK) && in_v && (sum == 8'd0);
    wr_en   = (state == PAYLOAD) && in_v;
    rd_en   = chk_ok || ((state == DRAIN) && (rd != frame_len - 8'd1));
    rd_addr = chk_ok ? '0 : AW'(rd + 8'd1);
  end

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .wr_en     (wr_en),
    .wr_addr   (AW'(idx)),
    .wr_data   (in_d),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (pl_data)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      acc        <= 8'd0;
      frame_len  <= 8'd0;
      idx        <= 8'd0;
      rd         <= 8'd0;
      to_cnt     <= '0;
      pend_valid <= 1'b0;
      pend_data  <= 8'd0;
      pl_valid   <= 1'b0;
      pl_last    <= 1'b0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= ERR_NONE;
      busy       <= 1'b0;
    end else begin
      pl_valid  <= 1'b0;
      pl_last   <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;

      if (state == DRAIN) begin
        if (rx_done) begin
          pend_valid <= 1'b1;
          pend_data  <= rx_data;
        end
      end else if (pend_valid) begin
        pend_valid <= rx_done;
        if (rx_done) pend_data <= rx_data;
      end

      if (rx_done || in_v || !active || to_hit) to_cnt <= '0;
      else                                      to_cnt <= to_cnt + TO_W'(1);

      case (state)
        IDLE: begin
          if (in_v && (in_d == HDR_BYTE)) begin
            acc   <= 8'd0;
            state <= LEN;
            busy  <= 1'b1;
          end
        end

        LEN: begin
          if (in_v) begin
            if ((in_d == 8'd0) || (in_d > MAX_LEN_B)) begin
              frame_err <= 1'b1;
              err_code  <= ERR_LEN;
              state     <= IDLE;
              busy      <= 1'b0;
            end else begin
              frame_len <= in_d;
              acc       <= in_d;
              idx       <= 8'd0;
              state     <= PAYLOAD;
            end
          end else if (to_hit) begin
            frame_err <= 1'b1;
            err_code  <= ERR_TO;
            state     <= IDLE;
            busy      <= 1'b0;
          end
        end

        PAYLOAD: begin
          if (in_v) begin
            acc <= sum;
            idx <= idx + 8'd1;
            if (idx == frame_len - 8'd1) state <= CHK;
          end else if (to_hit) begin
            frame_err <= 1'b1;
            err_code  <= ERR_TO;
            state     <= IDLE;
            busy      <= 1'b0;
          end
        end

        // The first payload byte is launched on the checksum edge so it appears one cycle later.
        CHK: begin
          if (in_v) begin
            if (sum == 8'd0) begin
              state    <= DRAIN;
              rd       <= 8'd0;
              pl_valid <= 1'b1;
              frame_ok <= 1'b1;
              pl_last  <= (frame_len == 8'd1);
            end else begin
              frame_err <= 1'b1;
              err_code  <= ERR_CHK;
              state     <= IDLE;
              busy      <= 1'b0;
            end
          end else if (to_hit) begin
            frame_err <= 1'b1;
            err_code  <= ERR_TO;
            state     <= IDLE;
            busy      <= 1'b0;
          end
        end

        DRAIN: begin
          if (rd == frame_len - 8'd1) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            rd       <= rd + 8'd1;
            pl_valid <= 1'b1;
            pl_last  <= (rd + 8'd1 == frame_len - 8'd1);
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_ctrl.sv
// ---- tb_uart_frame_ctrl : scoreboard bench for uart_frame_ctrl, rev 1.0 ----
`default_nettype none

module tb_uart_frame_ctrl;

  localparam int CLK_FREQ = 1000000;
  localparam int UART_BPS = 100000;
  localparam int TO_BYTES = 3;
  localparam int TO_CYC   = TO_BYTES * 10 * CLK_FREQ / UART_BPS;  // 300 cycles

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic       rx_done   = 1'b0;
  logic [7:0] rx_data   = 8'h00;
  logic       pl_valid;
  logic [7:0] pl_data;
  logic       pl_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  uart_frame_ctrl #(
    .CLK_FREQ (CLK_FREQ),
    .UART_BPS (UART_BPS),
    .HDR_BYTE (8'h55),
    .MAX_LEN  (16),
    .TO_BYTES (TO_BYTES)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .rx_done   (rx_done),
    .rx_data   (rx_data),
    .pl_valid  (pl_valid),
    .pl_data   (pl_data),
    .pl_last   (pl_last),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    bit         last;
    bit         ok;
    logic [1:0] code;
    int         at;
  } exp_t;

  exp_t q[$];
  int   npass  = 0;
  int   ntotal = 0;
  int   last_cyc = 0;

  task automatic check(input string name, input longint act, input longint exp);
    ntotal++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic exp_pl(input logic [7:0] d, input bit last, input bit ok, input int at);
    exp_t e;
    e.is_err = 1'b0; e.data = d; e.last = last; e.ok = ok; e.code = 2'd0; e.at = at;
    q.push_back(e);
  endtask

  task automatic exp_err(input logic [1:0] code, input int at);
    exp_t e;
    e.is_err = 1'b1; e.data = 8'h00; e.last = 1'b0; e.ok = 1'b0; e.code = code; e.at = at;
    q.push_back(e);
  endtask

  // last_cyc is the cycle index of the edge that sampled the byte; outputs from that edge show at cycle last_cyc.
  task automatic send(input logic [7:0] b);
    @(negedge sys_clk);
    rx_done = 1'b1;
    rx_data = b;
    @(posedge sys_clk);
    #1;
    rx_done  = 1'b0;
    last_cyc = cyc;
  endtask

  always @(negedge sys_clk) begin
    if (sys_rst_n && (pl_valid || frame_err || frame_ok)) begin
      if (q.size() == 0) begin
        ntotal++;
        $display("FAIL unexpected_output: pl_valid=%0b frame_ok=%0b frame_err=%0b data=%0h at cycle %0d",
                 pl_valid, frame_ok, frame_err, pl_data, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("frame_err", frame_err, e.is_err);
        check("pl_valid", pl_valid, !e.is_err);
        check("cycle", cyc, e.at);
        if (e.is_err) begin
          check("err_code", err_code, e.code);
          check("busy_after_err", busy, 0);
        end else begin
          check("pl_data", pl_data, e.data);
          check("pl_last", pl_last, e.last);
          check("frame_ok", frame_ok, e.ok);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_pl_valid"},  pl_valid,  0);
    check({tag, "_pl_data"},   pl_data,   0);
    check({tag, "_pl_last"},   pl_last,   0);
    check({tag, "_frame_ok"},  frame_ok,  0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_err_code"},  err_code,  0);
    check({tag, "_busy"},      busy,      0);
  endtask

  initial begin
    #3 sys_rst_n = 1'b0;
    #20;
    check_all_zero("reset");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);

    // Good frame: 02+12+34+B8 = 0x100
    send(8'h55); send(8'h02); send(8'h12); send(8'h34); send(8'hB8);
    exp_pl(8'h12, 0, 1, last_cyc);
    exp_pl(8'h34, 1, 0, last_cyc + 1);
    repeat (5) @(negedge sys_clk);

    // Bad checksum
    send(8'h55); send(8'h02); send(8'h12); send(8'h34); send(8'hB9);
    exp_err(2'd2, last_cyc);
    repeat (4) @(negedge sys_clk);

    // Bad lengths: zero and MAX_LEN+1
    send(8'h55); send(8'h00);
    exp_err(2'd1, last_cyc);
    repeat (3) @(negedge sys_clk);
    send(8'h55); send(8'h11);
    exp_err(2'd1, last_cyc);
    repeat (3) @(negedge sys_clk);

    // Timeout after the first payload byte, then a clean recovery frame
    send(8'h55); send(8'h03); send(8'hAA);
    exp_err(2'd3, last_cyc + TO_CYC);
    repeat (TO_CYC + 5) @(negedge sys_clk);
    send(8'h55); send(8'h01); send(8'h7F); send(8'h80);
    exp_pl(8'h7F, 1, 1, last_cyc);
    repeat (4) @(negedge sys_clk);

    // Garbage before header; header value inside the frame is plain payload (01+55+AA = 0x100)
    send(8'h00); send(8'hFF); send(8'h55); send(8'h01); send(8'h55); send(8'hAA);
    exp_pl(8'h55, 1, 1, last_cyc);
    repeat (4) @(negedge sys_clk);

    // Header forced during DRAIN starts the next frame from the pending register
    send(8'h55); send(8'h03); send(8'h01); send(8'h02); send(8'h03); send(8'hF7);
    exp_pl(8'h01, 0, 1, last_cyc);
    exp_pl(8'h02, 0, 0, last_cyc + 1);
    exp_pl(8'h03, 1, 0, last_cyc + 2);
    send(8'h55);
    repeat (4) @(negedge sys_clk);
    check("pending_hdr_busy", busy, 1);
    send(8'h02); send(8'h10); send(8'h20); send(8'hCE);
    exp_pl(8'h10, 0, 1, last_cyc);
    exp_pl(8'h20, 1, 0, last_cyc + 1);
    repeat (4) @(negedge sys_clk);

    // Asynchronous reset in the middle of a payload
    send(8'h55); send(8'h04); send(8'h01); send(8'h02);
    @(negedge sys_clk);
    check("busy_before_reset", busy, 1);
    #2 sys_rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    send(8'h55); send(8'h01); send(8'h7F); send(8'h80);
    exp_pl(8'h7F, 1, 1, last_cyc);
    repeat (6) @(negedge sys_clk);

    check("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

`default_nettype wire
